cpu_bus_arb: RTL and testbench
==============================

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have ports: i_rst  in  1  reset; synchronous and active-high.
REQ-003 SHALL have ports: i_cpu_addr/i_cpu_wn/i_cpu_wdata  in  16/1/8  CPU master request (wn=0 means write).
REQ-004 SHALL have ports: o_cpu_rdy  out  1  CPU ready; 0 stalls the CPU.
REQ-005 SHALL have ports: i_spr_req  in  1  sprite DMA request; i_spr_addr/i_spr_wn/i_spr_wdata  in  16/1/8; o_spr_gnt  out  1.
REQ-006 SHALL have ports: i_dmc_req  in  1  DMC sample fetch request; i_dmc_addr  in  16, read-only; o_dmc_gnt  out  1.
REQ-007 SHALL have ports: o_bus_addr/o_bus_wn/o_bus_wdata  out  16/1/8  shared bus toward memory and registers.
REQ-008 SHALL have ports: i_bus_rdata  in  8  read data; o_rdata  out  8  i_bus_rdata passed straight through to all masters.
REQ-009 SHALL have ports: o_dma_busy  out  1  high whenever o_cpu_rdy=0.
REQ-010 SHALL have ports: o_stall_cnt  out  16  saturating count of CPU stall cycles.

Function
REQ-011 SHALL implement states ARB_CPU, ARB_HALT and ARB_DMA, held in a 2-bit register; the code 2'b11 SHALL return to ARB_CPU.
REQ-012 ARB_CPU: the bus SHALL carry the CPU signals and o_cpu_rdy SHALL be 1. If (i_spr_req|i_dmc_req) is high and i_cpu_wn=1, the next state SHALL be ARB_HALT.
REQ-013 ARB_CPU with a DMA request pending and i_cpu_wn=0 (CPU write) SHALL stay in ARB_CPU; the halt SHALL be taken on the first subsequent CPU read cycle.
REQ-014 ARB_HALT SHALL last exactly 1 cycle with o_cpu_rdy=0. The bus SHALL carry i_cpu_addr with o_bus_wn=1 (dummy read) and both grants SHALL be 0. The next state SHALL be ARB_DMA.
REQ-015 ARB_DMA: o_cpu_rdy SHALL be 0. Grants SHALL be combinational and evaluated every cycle:
  - o_dmc_gnt = i_dmc_req;
  - o_spr_gnt = i_spr_req & ~i_dmc_req (DMC has fixed priority).
REQ-016 ARB_DMA: the bus SHALL carry the signals of the granted master. A DMC grant SHALL force o_bus_wn=1 and o_bus_wdata=0.
REQ-017 ARB_DMA with neither request high SHALL drive o_bus_wn=1 with the address held at its last value. The next state SHALL be ARB_CPU, with o_cpu_rdy=1 on the following cycle.
REQ-018 A request that deasserts and reasserts within ARB_DMA SHALL be granted without a new halt cycle.
REQ-019 A DMC request arriving mid sprite burst SHALL take the bus for every cycle it is held. The sprite master SHALL see o_spr_gnt=0 for those cycles and SHALL hold its request.
REQ-020 Grants SHALL never both be 1 in the same cycle. A grant SHALL never be 1 outside ARB_DMA.
REQ-021 A transfer occurs in each cycle where req & gnt are both high; the read data of that cycle SHALL be valid on o_rdata in the same cycle.
REQ-022 o_stall_cnt SHALL increment by 1 on each cycle with o_cpu_rdy=0 and SHALL saturate at 16'hFFFF (no wrap).
REQ-023 o_stall_cnt SHALL clear on reset only.

Reset
REQ-024 i_rst=1 at a clock edge SHALL force state to ARB_CPU and o_stall_cnt to 0.
REQ-025 During and after reset the outputs SHALL be: o_cpu_rdy=1, o_spr_gnt=0, o_dmc_gnt=0, o_dma_busy=0, bus = CPU signals.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately. Requesters SHALL see their grant drop on the next cycle.

Configuration
REQ-027 Macro CPU_BUS_ARB_DMC_EN defined: the DMC port SHALL be fully functional as specified above.
REQ-028 Macro CPU_BUS_ARB_DMC_EN undefined: the DMC ports SHALL still exist, but i_dmc_req and i_dmc_addr SHALL be ignored. o_dmc_gnt SHALL be constant 0, and o_spr_gnt SHALL equal i_spr_req in ARB_DMA.

Verification
REQ-029 Reset, CPU reads 16'h8000 -> o_bus_addr=16'h8000, o_cpu_rdy=1, o_stall_cnt=0.
REQ-030 i_spr_req rises during a CPU read -> 1 ARB_HALT cycle. The next 512 cycles SHALL show o_spr_gnt=1; o_cpu_rdy SHALL return 1 exactly one cycle after i_spr_req falls; o_stall_cnt=513.
REQ-031 i_spr_req rises while i_cpu_wn=0 for 2 consecutive cycles -> the halt SHALL start only after the third (read) cycle.
REQ-032 With CPU_BUS_ARB_DMC_EN defined, i_dmc_req pulses 1 cycle (addr 16'hC000) mid sprite burst -> o_dmc_gnt=1 and o_bus_addr=16'hC000 in that cycle, o_spr_gnt=0 in that cycle, and the sprite burst SHALL resume on the next cycle.
REQ-033 The same stimulus without the macro -> o_dmc_gnt SHALL stay 0 and o_spr_gnt SHALL be uninterrupted.
REQ-034 Preload o_stall_cnt near 16'hFFFF via a long stall -> the count SHALL hold at 16'hFFFF. Then assert i_rst mid-burst -> next cycle o_cpu_rdy=1, grants=0, count=0.

Source files
------------

// File: rtl/cpu_bus_arb.sv
// CPU bus arbiter: sprite DMA and DMC fetches steal the shared bus from the CPU after one dummy-read halt cycle.
// Latency: one halt cycle before the first grant, then combinational grants; read data passes through with no delay.
// Backpressure: o_cpu_rdy=0 stalls the CPU. Requesters hold their request until granted. Build option: CPU_BUS_ARB_DMC_EN enables the DMC port.
module cpu_bus_arb (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_rdy,
  input  logic        i_spr_req,
  input  logic [15:0] i_spr_addr,
  input  logic        i_spr_wn,
  input  logic [7:0]  i_spr_wdata,
  output logic        o_spr_gnt,
  input  logic        i_dmc_req,
  input  logic [15:0] i_dmc_addr,
  output logic        o_dmc_gnt,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic [7:0]  o_rdata,
  output logic        o_dma_busy,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ARB_CPU  = 2'b00,
    ARB_HALT = 2'b01,
    ARB_DMA  = 2'b10
  } arb_state_t;

  arb_state_t  state;
  logic [15:0] addr_hold;
  logic [15:0] stall_cnt;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        cpu_owns;
  logic        in_dma;
  logic        spr_gnt;
  logic        dmc_gnt;

`ifdef CPU_BUS_ARB_DMC_EN
  assign dmc_req  = i_dmc_req;
  assign dmc_addr = i_dmc_addr;
`else
  // DMC port is present but inert in this build
  assign dmc_req  = i_dmc_req & 1'b0;
  assign dmc_addr = i_dmc_addr & 16'h0000;
`endif

  // The CPU owns the bus in ARB_CPU, in the unused 2'b11 code, and while reset is held
  assign cpu_owns = i_rst | ~((state == ARB_HALT) | (state == ARB_DMA));
  assign in_dma   = ~i_rst & (state == ARB_DMA);
  assign dmc_gnt  = in_dma & dmc_req;
  assign spr_gnt  = in_dma & i_spr_req & ~dmc_req;

  // Arbitration state: a halt is only taken on a CPU read cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ARB_CPU;
    end else begin
      case (state)
        ARB_CPU:  if ((i_spr_req | dmc_req) & i_cpu_wn) state <= ARB_HALT;
        ARB_HALT: state <= ARB_DMA;
        ARB_DMA:  if (~i_spr_req & ~dmc_req) state <= ARB_CPU;
        default:  state <= ARB_CPU;
      endcase
    end
  end

  // Bus mux: DMC beats sprite. Halt and idle DMA cycles are reads with no write data.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    if (~cpu_owns) begin
      o_bus_wn    = 1'b1;
      o_bus_wdata = 8'h00;
      if (dmc_gnt) begin
        o_bus_addr = dmc_addr;
      end else if (spr_gnt) begin
        o_bus_addr  = i_spr_addr;
        o_bus_wn    = i_spr_wn;
        o_bus_wdata = i_spr_wdata;
      end else if (state == ARB_HALT) begin
        o_bus_addr = i_cpu_addr;
      end else begin
        o_bus_addr = addr_hold;
      end
    end
  end

  // Remember the last driven address so an idle DMA cycle does not glitch the bus
  always_ff @(posedge i_clk) begin
    if (i_rst) addr_hold <= 16'h0000;
    else       addr_hold <= o_bus_addr;
  end

  // Saturating count of cycles the CPU spent stalled; only reset clears it
  always_ff @(posedge i_clk) begin
    if (i_rst)                                stall_cnt <= 16'h0000;
    else if (~cpu_owns && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
  end

  assign o_cpu_rdy   = cpu_owns;
  assign o_dma_busy  = ~cpu_owns;
  assign o_spr_gnt   = spr_gnt;
  assign o_dmc_gnt   = dmc_gnt;
  assign o_rdata     = i_bus_rdata;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Self-checking bench for cpu_bus_arb: reset, halt/burst timing, grant table, write deferral, DMC preemption, saturation and reset abort.
// Latency: inputs are driven 1 time unit after the rising edge and outputs are sampled 2 time units later.
// Backpressure: the sprite master holds its request through DMC preemption; the bench follows o_cpu_rdy timing.
module tb_cpu_bus_arb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_cpu_addr;
  logic        i_cpu_wn;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_rdy;
  logic        i_spr_req;
  logic [15:0] i_spr_addr;
  logic        i_spr_wn;
  logic [7:0]  i_spr_wdata;
  logic        o_spr_gnt;
  logic        i_dmc_req;
  logic [15:0] i_dmc_addr;
  logic        o_dmc_gnt;
  logic [15:0] o_bus_addr;
  logic        o_bus_wn;
  logic [7:0]  o_bus_wdata;
  logic [7:0]  i_bus_rdata;
  logic [7:0]  o_rdata;
  logic        o_dma_busy;
  logic [15:0] o_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  cpu_bus_arb dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wn(i_cpu_wn), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdy(o_cpu_rdy),
    .i_spr_req(i_spr_req), .i_spr_addr(i_spr_addr), .i_spr_wn(i_spr_wn),
    .i_spr_wdata(i_spr_wdata), .o_spr_gnt(o_spr_gnt),
    .i_dmc_req(i_dmc_req), .i_dmc_addr(i_dmc_addr), .o_dmc_gnt(o_dmc_gnt),
    .o_bus_addr(o_bus_addr), .o_bus_wn(o_bus_wn), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .o_rdata(o_rdata),
    .o_dma_busy(o_dma_busy), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct {
    logic        spr_req;
    logic        dmc_req;
    logic [15:0] spr_addr;
    logic        spr_wn;
    logic [7:0]  spr_wdata;
    logic [15:0] dmc_addr;
    logic [7:0]  rdata;
    logic        e_gs;
    logic        e_gd;
    logic [15:0] e_addr;
    logic        e_wn;
    logic [7:0]  e_wd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int bad;
    int n;

    i_rst = 1'b1;
    i_cpu_addr = 16'h1111; i_cpu_wn = 1'b1; i_cpu_wdata = 8'h00;
    i_spr_req = 1'b0; i_spr_addr = 16'h0000; i_spr_wn = 1'b1; i_spr_wdata = 8'h00;
    i_dmc_req = 1'b0; i_dmc_addr = 16'h0000; i_bus_rdata = 8'h00;

    // Reset state
    cyc(); cyc();
    #2;
    chk("rst_rdy",  o_cpu_rdy,   1);
    chk("rst_spr",  o_spr_gnt,   0);
    chk("rst_dmc",  o_dmc_gnt,   0);
    chk("rst_busy", o_dma_busy,  0);
    chk("rst_cnt",  o_stall_cnt, 0);
    chk("rst_addr", o_bus_addr,  16'h1111);

    // Plain CPU read
    cyc(); i_rst = 1'b0; i_cpu_addr = 16'h8000; i_cpu_wn = 1'b1;
    #2;
    chk("cpu_addr", o_bus_addr,  16'h8000);
    chk("cpu_rdy",  o_cpu_rdy,   1);
    chk("cpu_cnt",  o_stall_cnt, 0);

    // Sprite burst of 512 transfers
    cyc(); i_spr_req = 1'b1; i_spr_addr = 16'h0200; i_spr_wn = 1'b0;
    #2;
    chk("req_cycle_rdy", o_cpu_rdy, 1);
    chk("req_cycle_gs",  o_spr_gnt, 0);
    cyc(); #2;
    chk("halt_rdy",  o_cpu_rdy,  0);
    chk("halt_gs",   o_spr_gnt,  0);
    chk("halt_gd",   o_dmc_gnt,  0);
    chk("halt_wn",   o_bus_wn,   1);
    chk("halt_addr", o_bus_addr, 16'h8000);
    chk("halt_busy", o_dma_busy, 1);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      cyc();
      i_spr_addr = 16'h0200 + 16'(i);
      #2;
      if (o_spr_gnt !== 1'b1 || o_cpu_rdy !== 1'b0 || o_bus_addr !== 16'h0200 + 16'(i))
        bad++;
    end
    chk("burst_bad_cycles", 16'(bad), 0);
    cyc(); i_spr_req = 1'b0;
    #2;
    chk("idle_rdy", o_cpu_rdy,   0);
    chk("idle_gs",  o_spr_gnt,   0);
    chk("idle_wn",  o_bus_wn,    1);
    chk("idle_addr", o_bus_addr, 16'h03FF);
    chk("stall_513", o_stall_cnt, 16'd513);
    cyc(); #2;
    chk("return_rdy",  o_cpu_rdy,   1);
    chk("return_busy", o_dma_busy,  0);
    chk("stall_514",   o_stall_cnt, 16'd514);

    // Table of DMA-state grant/mux vectors
    tbl[0] = '{1'b1, 1'b0, 16'h1234, 1'b0, 8'h5A, 16'hC000, 8'h11, 1'b1, 1'b0, 16'h1234, 1'b0, 8'h5A};
`ifdef CPU_BUS_ARB_DMC_EN
    tbl[1] = '{1'b1, 1'b1, 16'h1235, 1'b1, 8'hA5, 16'hC000, 8'h22, 1'b0, 1'b1, 16'hC000, 1'b1, 8'h00};
`else
    tbl[1] = '{1'b1, 1'b1, 16'h1235, 1'b1, 8'hA5, 16'hC000, 8'h22, 1'b1, 1'b0, 16'h1235, 1'b1, 8'hA5};
`endif
    tbl[2] = '{1'b1, 1'b0, 16'h1236, 1'b0, 8'h3C, 16'hC000, 8'h33, 1'b1, 1'b0, 16'h1236, 1'b0, 8'h3C};
`ifdef CPU_BUS_ARB_DMC_EN
    tbl[3] = '{1'b1, 1'b1, 16'h1237, 1'b0, 8'hC3, 16'hC0FF, 8'h44, 1'b0, 1'b1, 16'hC0FF, 1'b1, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 16'h9999, 1'b0, 8'hFF, 16'hDEAD, 8'h55, 1'b0, 1'b0, 16'hC0FF, 1'b1, 8'h00};
`else
    tbl[3] = '{1'b1, 1'b1, 16'h1237, 1'b0, 8'hC3, 16'hC0FF, 8'h44, 1'b1, 1'b0, 16'h1237, 1'b0, 8'hC3};
    tbl[4] = '{1'b0, 1'b0, 16'h9999, 1'b0, 8'hFF, 16'hDEAD, 8'h55, 1'b0, 1'b0, 16'h1237, 1'b1, 8'h00};
`endif
    cyc(); i_spr_req = 1'b1; i_spr_addr = 16'h1234;
    cyc();
    for (int r = 0; r < 5; r++) begin
      cyc();
      i_spr_req = tbl[r].spr_req; i_dmc_req = tbl[r].dmc_req;
      i_spr_addr = tbl[r].spr_addr; i_spr_wn = tbl[r].spr_wn; i_spr_wdata = tbl[r].spr_wdata;
      i_dmc_addr = tbl[r].dmc_addr; i_bus_rdata = tbl[r].rdata;
      #2;
      chk($sformatf("tbl%0d_gs", r),    o_spr_gnt,   tbl[r].e_gs);
      chk($sformatf("tbl%0d_gd", r),    o_dmc_gnt,   tbl[r].e_gd);
      chk($sformatf("tbl%0d_addr", r),  o_bus_addr,  tbl[r].e_addr);
      chk($sformatf("tbl%0d_wn", r),    o_bus_wn,    tbl[r].e_wn);
      chk($sformatf("tbl%0d_wd", r),    o_bus_wdata, tbl[r].e_wd);
      chk($sformatf("tbl%0d_rdata", r), o_rdata,     tbl[r].rdata);
      chk($sformatf("tbl%0d_rdy", r),   o_cpu_rdy,   0);
      chk($sformatf("tbl%0d_excl", r),  o_spr_gnt & o_dmc_gnt, 0);
    end
    cyc(); #2;
    chk("tbl_end_rdy",  o_cpu_rdy,  1);
    chk("tbl_end_addr", o_bus_addr, 16'h8000);

    // CPU writes defer the halt to the first read
    cyc(); i_cpu_wn = 1'b0; i_cpu_addr = 16'h4000; i_cpu_wdata = 8'h77;
    i_spr_req = 1'b1; i_spr_addr = 16'h0300; i_spr_wn = 1'b1;
    #2;
    chk("wr1_rdy",   o_cpu_rdy,   1);
    chk("wr1_wn",    o_bus_wn,    0);
    chk("wr1_wdata", o_bus_wdata, 8'h77);
    cyc(); #2;
    chk("wr2_rdy", o_cpu_rdy, 1);
    cyc(); i_cpu_wn = 1'b1;
    #2;
    chk("rd3_rdy", o_cpu_rdy, 1);
    cyc(); #2;
    chk("halt2_rdy",  o_cpu_rdy,  0);
    chk("halt2_gs",   o_spr_gnt,  0);
    chk("halt2_addr", o_bus_addr, 16'h4000);
    cyc(); #2;
    chk("burst2_gs",   o_spr_gnt,  1);
    chk("burst2_addr", o_bus_addr, 16'h0300);

    // One-cycle DMC pulse in the middle of the sprite burst
    cyc(); i_dmc_req = 1'b1; i_dmc_addr = 16'hC000; i_spr_addr = 16'h0301;
    #2;
`ifdef CPU_BUS_ARB_DMC_EN
    chk("pulse_gd",   o_dmc_gnt,  1);
    chk("pulse_gs",   o_spr_gnt,  0);
    chk("pulse_addr", o_bus_addr, 16'hC000);
`else
    chk("pulse_gd",   o_dmc_gnt,  0);
    chk("pulse_gs",   o_spr_gnt,  1);
    chk("pulse_addr", o_bus_addr, 16'h0301);
`endif
    cyc(); i_dmc_req = 1'b0;
    #2;
    chk("resume_gs",   o_spr_gnt,  1);
    chk("resume_gd",   o_dmc_gnt,  0);
    chk("resume_addr", o_bus_addr, 16'h0301);

`ifdef CPU_BUS_ARB_DMC_EN
    // Sprite drops while DMC holds the bus, then re-requests without a new halt
    cyc(); i_spr_req = 1'b0; i_dmc_req = 1'b1; i_dmc_addr = 16'hC010;
    #2;
    chk("handoff_gd",  o_dmc_gnt, 1);
    chk("handoff_rdy", o_cpu_rdy, 0);
    cyc(); i_spr_req = 1'b1; i_dmc_req = 1'b0;
    #2;
    chk("regrant_gs",  o_spr_gnt, 1);
    chk("regrant_rdy", o_cpu_rdy, 0);
`endif

    // Long stall to saturate the counter
    n = 0;
    while (o_stall_cnt != 16'hFFFF && n < 70000) begin
      cyc();
      n++;
    end
    #2;
    chk("sat_reach", o_stall_cnt, 16'hFFFF);
    cyc(); cyc(); cyc(); #2;
    chk("sat_hold",    o_stall_cnt, 16'hFFFF);
    chk("sat_burst_gs", o_spr_gnt,  1);

    // Reset in the middle of the burst
    cyc(); i_rst = 1'b1;
    cyc(); #2;
    chk("abort_rdy",  o_cpu_rdy,   1);
    chk("abort_gs",   o_spr_gnt,   0);
    chk("abort_gd",   o_dmc_gnt,   0);
    chk("abort_cnt",  o_stall_cnt, 0);
    chk("abort_busy", o_dma_busy,  0);
    cyc(); i_rst = 1'b0; i_spr_req = 1'b0; i_cpu_addr = 16'h8000;
    #2;
    chk("post_abort_rdy",  o_cpu_rdy,  1);
    chk("post_abort_addr", o_bus_addr, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
